// File: rtl/tristate_arb_pkg.sv
// Shared types and helpers for tristate bus arbiters.
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int DEF_MAX_HOLD    = 16;
  localparam int DEF_TURN_CYCLES = 1;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_rr_pick.sv
// Round-robin pick: rotate request vector by pointer, take lowest set bit, rotate back.
module tristate_rr_pick
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic                    found,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int W = idx_w(N_REQ);
  localparam logic [W:0] N_VAL = (W+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [W-1:0]     pos;
  logic [W:0]       sum;

  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    found = |rot;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = W'(i);
    end
    // Undo the rotation modulo N_REQ without a divider.
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= N_VAL) sum = sum - N_VAL;
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin tristate bus arbiter with tenure limit and turnaround gap between owners.
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        grant,
  output logic [idx_w(N_REQ)-1:0] owner,
  output logic                    bus_busy
);

  localparam int OW = idx_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);

  arb_state_e    state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;
  logic [OW-1:0] ptr;
  logic [OW-1:0] ptr_next;
  logic          pick_found;
  logic [OW-1:0] pick_idx;
  logic          owner_req;
  logic          others_req;
  logic          release_now;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  tristate_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    owner_req   = req[owner];
    others_req  = |(req & ~onehot(owner));
    // Voluntary drop and forced release collapse into one TURN entry.
    release_now = !owner_req || ((hold_cnt == HOLD_MAX) && others_req);
    ptr_next    = (owner == LAST_IDX) ? '0 : owner + OW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      bus_busy <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            grant    <= onehot(pick_idx);
            owner    <= pick_idx;
            bus_busy <= 1'b1;
            hold_cnt <= HW'(1);
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= TURN;
            grant    <= '0;
            ptr      <= ptr_next;
            turn_cnt <= TW'(1);
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            if (pick_found) begin
              state    <= GRANT;
              grant    <= onehot(pick_idx);
              owner    <= pick_idx;
              hold_cnt <= HW'(1);
            end else begin
              state    <= IDLE;
              bus_busy <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed and random checks for tristate_bus_arbiter (N_REQ=4, MAX_HOLD=4, TURN_CYCLES=1).
module tb_tristate_bus_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int TC   = 1;
  localparam int WAIT_MAX = 3 * (HOLD + TC) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       bus_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         do_rst;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
  } vec_t;

  vec_t vt[$];

  tristate_bus_arbiter #(
    .N_REQ(N),
    .MAX_HOLD(HOLD),
    .TURN_CYCLES(TC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .owner(owner),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic apply_reset();
    req   = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 0, 32'(grant), 0);
    chk("rst_owner", 0, 32'(owner), 0);
    chk("rst_busy", 0, 32'(bus_busy), 0);
    reset = 1'b1;
  endtask

  function automatic void add(input bit r, input logic [3:0] rq, input logic [3:0] g,
                              input logic [1:0] o, input logic b);
    vt.push_back('{r, rq, g, o, b});
  endfunction

  initial begin
    int         wait_cnt[N];
    int         zeros;
    logic [3:0] last_g;
    logic [3:0] rr;

    // Single requester grant and release, then back to IDLE.
    add(1, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    // All requesting: forced rotation with one dead cycle each.
    for (int k = 0; k < N; k++) begin
      for (int h = 0; h < HOLD; h++)
        add((k == 0) && (h == 0), 4'b1111, 4'(1 << k), 2'(k), 1);
      add(0, 4'b1111, 4'b0000, 2'(k), 1);
    end
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    // Owner drops exactly when the hold limit is hit: one TURN, then index 2.
    add(1, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0000, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    // Forced release, competitor leaves, released owner wins again via wrap.
    add(1, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0000, 2'd0, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);

    foreach (vt[i]) begin
      if (vt[i].do_rst) apply_reset();
      req = vt[i].rq;
      @(posedge clk);
      #1;
      chk("vec_grant", i, 32'(grant), 32'(vt[i].g));
      chk("vec_owner", i, 32'(owner), 32'(vt[i].o));
      chk("vec_busy", i, 32'(bus_busy), 32'(vt[i].b));
    end

    // Sole requester keeps the bus with no gaps.
    apply_reset();
    req = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      chk("sole_grant", c, 32'(grant), 32'h2);
      chk("sole_busy", c, 32'(bus_busy), 1);
    end

    // Asynchronous reset mid-cycle clears a live grant, pointer restarts at 0.
    apply_reset();
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("pre_async_grant", 0, 32'(grant), 32'h4);
    #3 reset = 1'b0;
    #1;
    chk("async_grant", 0, 32'(grant), 0);
    chk("async_owner", 0, 32'(owner), 0);
    chk("async_busy", 0, 32'(bus_busy), 0);
    req = 4'b0000;
    @(posedge clk);
    #1 reset = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    #1;
    chk("post_rst_grant", 0, 32'(grant), 32'h1);
    chk("post_rst_owner", 0, 32'(owner), 0);

    // Random traffic: one-hot grant, turnaround gap, bounded waiting.
    apply_reset();
    rr     = '0;
    zeros  = TC;
    last_g = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
      req = rr;
      @(posedge clk);
      #1;
      chk("rnd_onehot", c, 32'($countones(grant) <= 1), 1);
      if (grant != 0) begin
        chk("rnd_owner_match", c, 32'(grant), 32'(1 << owner));
        chk("rnd_busy", c, 32'(bus_busy), 1);
        if (last_g != 0 && grant != last_g)
          chk("rnd_gap", c, 32'(zeros >= TC), 1);
        last_g = grant;
        zeros  = 0;
      end else begin
        zeros++;
      end
      for (int i = 0; i < N; i++) begin
        if (rr[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk("rnd_wait", i, 32'(wait_cnt[i] <= WAIT_MAX), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
